// File: rtl/rc4_ksa_engine_if.sv
// Control and S-box RAM bundle for the RC4 key-scheduling engine.
// The engine takes the slave side; the decryption controller and the RAM take the master side.
interface rc4_ksa_if #(
    parameter int KEY_BYTES = 3
);
    logic                   start;
    logic                   abort;
    logic [KEY_BYTES*8-1:0] key;
    logic                   busy;
    logic                   done;
    logic [7:0]             mem_addr;
    logic [7:0]             mem_wdata;
    logic                   mem_wren;
    logic [7:0]             mem_rdata;

    modport slave (
        input  start, abort, key, mem_rdata,
        output busy, done, mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output start, abort, key, mem_rdata,
        input  busy, done, mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external 256x8 S-box RAM.
// Optionally fills S[i]=i, then runs the 256-step swap loop
// j = j + S[i] + key[i mod KEY_BYTES]; swap(S[i], S[j]).
// The RAM read latency is a parameter; each read waits MEM_RD_LAT cycles.
module rc4_ksa_engine #(
    parameter int KEY_BYTES  = 3,
    parameter int MEM_RD_LAT = 1,
    parameter int INIT_EN    = 1
) (
    input  logic      clk,
    input  logic      reset,
    rc4_ksa_if.slave  bus
);

    localparam int              KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KW-1:0]   K_LAST    = KW'(KEY_BYTES - 1);
    localparam logic [1:0]      WAIT_LAST = 2'(MEM_RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        RD_SI,
        WT_SI,
        RD_SJ,
        WT_SJ,
        WR_J,
        WR_I,
        DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [7:0]             i;
    logic [7:0]             j;
    logic [7:0]             si;
    logic [7:0]             sj;
    logic [KW-1:0]          k;
    logic [1:0]             wait_cnt;
    logic [KEY_BYTES*8-1:0] key_reg;

    logic [7:0]             addr_q;
    logic [7:0]             wdata_q;
    logic [7:0]             addr_d;
    logic [7:0]             wdata_d;
    logic                   wren_d;

    logic [7:0]             key_byte;
    logic                   wait_last;
    logic                   accept;
    logic                   run_abort;

    assign key_byte  = 8'(key_reg >> {k, 3'b000});
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign accept    = (state == IDLE) && bus.start && !bus.abort;
    assign run_abort = bus.abort && (state != IDLE) && (state != DONE);

    assign bus.mem_addr  = addr_d;
    assign bus.mem_wdata = wdata_d;
    assign bus.mem_wren  = wren_d;
    assign bus.busy      = (state != IDLE) && (state != DONE);
    assign bus.done      = (state == DONE);

    // State register; reset and abort both land in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and RAM port drive; address/data hold their last value unless a state owns them, and abort cancels any write this cycle.
    always_comb begin
        next_state = state;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wren_d     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (INIT_EN != 0) ? FILL : RD_SI;
                end
            end
            FILL: begin
                addr_d  = i;
                wdata_d = i;
                wren_d  = 1'b1;
                if (i == 8'hFF) begin
                    next_state = RD_SI;
                end
            end
            RD_SI: begin
                addr_d     = i;
                next_state = WT_SI;
            end
            WT_SI: begin
                addr_d = i;
                if (wait_last) begin
                    next_state = RD_SJ;
                end
            end
            RD_SJ: begin
                addr_d     = j;
                next_state = WT_SJ;
            end
            WT_SJ: begin
                addr_d = j;
                if (wait_last) begin
                    next_state = WR_J;
                end
            end
            WR_J: begin
                addr_d     = j;
                wdata_d    = si;
                wren_d     = 1'b1;
                next_state = WR_I;
            end
            WR_I: begin
                addr_d     = i;
                wdata_d    = sj;
                wren_d     = 1'b1;
                next_state = (i == 8'hFF) ? DONE : RD_SI;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (run_abort) begin
            next_state = IDLE;
            wren_d     = 1'b0;
        end
    end

    // Index, key and read-data registers advancing with the schedule; the key copy is taken only on an accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i        <= 8'd0;
            j        <= 8'd0;
            si       <= 8'd0;
            sj       <= 8'd0;
            k        <= '0;
            wait_cnt <= 2'd0;
            key_reg  <= '0;
            addr_q   <= 8'd0;
            wdata_q  <= 8'd0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            case (state)
                IDLE: begin
                    if (accept) begin
                        key_reg  <= bus.key;
                        i        <= 8'd0;
                        j        <= 8'd0;
                        k        <= '0;
                        wait_cnt <= 2'd0;
                    end
                end
                FILL: begin
                    i <= i + 8'd1;
                end
                RD_SI: begin
                    wait_cnt <= 2'd0;
                end
                WT_SI: begin
                    if (wait_last) begin
                        si <= bus.mem_rdata;
                        j  <= j + bus.mem_rdata + key_byte;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RD_SJ: begin
                    wait_cnt <= 2'd0;
                end
                WT_SJ: begin
                    if (wait_last) begin
                        sj <= bus.mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WR_I: begin
                    if (i != 8'hFF) begin
                        i <= i + 8'd1;
                        k <= (k == K_LAST) ? '0 : k + KW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Testbench for rc4_ksa_engine: three engine instances (defaults; 5-byte key with
// 3-cycle RAM; no fill phase) each with a behavioural S-box RAM. Expected done
// cycles and the full write trace of the default instance are queued when a run
// is started and consumed by a monitor whenever the DUT presents done or a write.
module tb_rc4_ksa_engine;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0 = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to time-stamp DUT events.
    always @(posedge clk) cyc <= cyc + 1;

    rc4_ksa_if #(.KEY_BYTES(3)) bus_a ();
    rc4_ksa_if #(.KEY_BYTES(5)) bus_b ();
    rc4_ksa_if #(.KEY_BYTES(3)) bus_c ();

    rc4_ksa_engine #(.KEY_BYTES(3), .MEM_RD_LAT(1), .INIT_EN(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    rc4_ksa_engine #(.KEY_BYTES(5), .MEM_RD_LAT(3), .INIT_EN(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));
    rc4_ksa_engine #(.KEY_BYTES(3), .MEM_RD_LAT(1), .INIT_EN(0)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c.slave));

    logic [2:0][7:0] addr_v;
    logic [2:0][7:0] wdata_v;
    logic [2:0]      wren_v;
    logic [2:0]      done_v;
    logic [2:0]      busy_v;

    assign addr_v[0]  = bus_a.mem_addr;
    assign addr_v[1]  = bus_b.mem_addr;
    assign addr_v[2]  = bus_c.mem_addr;
    assign wdata_v[0] = bus_a.mem_wdata;
    assign wdata_v[1] = bus_b.mem_wdata;
    assign wdata_v[2] = bus_c.mem_wdata;
    assign wren_v     = {bus_c.mem_wren, bus_b.mem_wren, bus_a.mem_wren};
    assign done_v     = {bus_c.done, bus_b.done, bus_a.done};
    assign busy_v     = {bus_c.busy, bus_b.busy, bus_a.busy};

    logic [7:0] ram  [3][256];
    logic [7:0] pipe [3][4];
    logic [2:0] load_req = 3'b000;

    // Behavioural RAMs: synchronous write, read data through a 4-deep pipe tapped at each instance's latency.
    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (load_req[n]) begin
                for (int a = 0; a < 256; a++) ram[n][a] <= 8'(a);
            end else if (wren_v[n]) begin
                ram[n][addr_v[n]] <= wdata_v[n];
            end
            pipe[n][0] <= ram[n][addr_v[n]];
            for (int s = 1; s < 4; s++) pipe[n][s] <= pipe[n][s-1];
        end
    end

    assign bus_a.mem_rdata = pipe[0][0];
    assign bus_b.mem_rdata = pipe[1][2];
    assign bus_c.mem_rdata = pipe[2][0];

    int          done_q [3][$];
    logic [15:0] wr_q[$];
    logic [15:0] wr_log[$];
    int          wr_cyc[$];
    logic [7:0]  gold [256];

    // Monitor: pops an expected done cycle on every done pulse and an expected (addr,data) on every write of instance A.
    always @(negedge clk) begin
        int          e;
        logic [15:0] w;
        if (!reset) begin
            for (int n = 0; n < 3; n++) begin
                if (done_v[n]) begin
                    checks++;
                    if (done_q[n].size() == 0) begin
                        failures++;
                        $display("[TB] FAIL done_%0d: unexpected done at cycle %0d, none expected", n, cyc);
                    end else begin
                        e = done_q[n].pop_front();
                        if (cyc != e) begin
                            failures++;
                            $display("[TB] FAIL done_%0d: done at cycle %0d, expected cycle %0d", n, cyc, e);
                        end
                    end
                end
            end
            if (wren_v[0]) begin
                checks++;
                wr_log.push_back({addr_v[0], wdata_v[0]});
                wr_cyc.push_back(cyc);
                if (wr_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL write_a: unexpected write addr=%h data=%h at cycle %0d", addr_v[0], wdata_v[0], cyc);
                end else begin
                    w = wr_q.pop_front();
                    if ({addr_v[0], wdata_v[0]} !== w) begin
                        failures++;
                        $display("[TB] FAIL write_a: got addr=%h data=%h, expected addr=%h data=%h (cycle %0d)",
                                 addr_v[0], wdata_v[0], w[15:8], w[7:0], cyc);
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] log_at(input int idx);
        if (idx < wr_log.size()) return wr_log[idx];
        return 16'hxxxx;
    endfunction

    function automatic int cyc_at(input int idx);
        if (idx < wr_cyc.size()) return wr_cyc[idx];
        return -1;
    endfunction

    // Reference RC4 key schedule; optionally queues the complete write trace including the fill phase.
    task automatic model_run(input logic [255:0] keyv, input int nk, input bit push_writes);
        logic [7:0] s [256];
        logic [7:0] jj;
        logic [7:0] tmp;
        logic [7:0] kb;
        for (int i = 0; i < 256; i++) begin
            s[i] = 8'(i);
            if (push_writes) wr_q.push_back({8'(i), 8'(i)});
        end
        jj = 8'd0;
        for (int i = 0; i < 256; i++) begin
            kb = keyv[8*(i % nk) +: 8];
            jj = jj + s[i] + kb;
            if (push_writes) begin
                wr_q.push_back({jj, s[i]});
                wr_q.push_back({8'(i), s[jj]});
            end
            tmp   = s[i];
            s[i]  = s[jj];
            s[jj] = tmp;
        end
        for (int i = 0; i < 256; i++) gold[i] = s[i];
    endtask

    task automatic check_ram(input int n, input string name);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        for (int a = 0; a < 256; a++) begin
            if (ram[n][a] !== gold[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL %s: %0d bytes differ, first at %h got %h expected %h",
                     name, bad, first, ram[n][first], gold[first]);
        end
    endtask

    // Pulses start on one instance and queues the done cycle counted from the start cycle.
    task automatic apply_stimulus(input int n, input logic [255:0] keyv, input int latency);
        t0 = cyc;
        done_q[n].push_back(t0 + latency);
        case (n)
            0: begin bus_a.key = keyv[23:0]; bus_a.start = 1'b1; end
            1: begin bus_b.key = keyv[39:0]; bus_b.start = 1'b1; end
            default: begin bus_c.key = keyv[23:0]; bus_c.start = 1'b1; end
        endcase
        tick(1);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        check_output($sformatf("busy_after_start_%0d", n), 32'(busy_v[n]), 32'd1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int c;
        c = 0;
        while (!done_v[n] && c < budget) begin
            tick(1);
            c++;
        end
        checks++;
        if (!done_v[n]) begin
            failures++;
            $display("[TB] FAIL done_wait_%0d: no done within %0d cycles, expected done", n, budget);
        end
        check_output($sformatf("busy_in_done_%0d", n), 32'(busy_v[n]), 32'd0);
        tick(1);
        check_output($sformatf("done_one_cycle_%0d", n), 32'(done_v[n]), 32'd0);
    endtask

    localparam logic [255:0] KEY_A = 256'h79654B;
    localparam logic [255:0] KEY_5 = 256'h0504030201;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.key = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.key = '0;
        bus_c.start = 1'b0; bus_c.abort = 1'b0; bus_c.key = '0;
        reset = 1'b1;
        tick(3);
        check_output("reset_outputs_a", {busy_v[0], done_v[0], wren_v[0], addr_v[0], wdata_v[0]}, 32'd0);
        reset = 1'b0;
        tick(2);

        // Defaults, key 4B 65 79: full write trace, first swap writes, latency, final RAM.
        $display("[TB] run 1: defaults");
        wr_log.delete(); wr_cyc.delete();
        model_run(KEY_A, 3, 1'b1);
        apply_stimulus(0, KEY_A, 1793);
        wait_done(0, 2000);
        check_output("fill_first", log_at(0), 16'h0000);
        check_output("fill_last", log_at(255), 16'hFFFF);
        check_output("fill_first_cycle", cyc_at(0), t0 + 1);
        check_output("fill_last_cycle", cyc_at(255), t0 + 256);
        check_output("swap0_wr_j", log_at(256), 16'h4B00);
        check_output("swap0_wr_i", log_at(257), 16'h004B);
        check_output("swap0_cycle", cyc_at(256), t0 + 261);
        check_output("wr_q_drained_1", wr_q.size(), 0);
        check_ram(0, "ram_run1");

        // Abort during the WR_J cycle of i=100.
        $display("[TB] run 2: abort");
        wr_log.delete(); wr_cyc.delete();
        model_run(KEY_A, 3, 1'b1);
        apply_stimulus(0, KEY_A, 1793);
        while (cyc < t0 + 861) tick(1);
        bus_a.abort = 1'b1;
        #1;
        check_output("abort_blocks_write", 32'(wren_v[0]), 32'd0);
        tick(1);
        bus_a.abort = 1'b0;
        check_output("busy_after_abort", 32'(busy_v[0]), 32'd0);
        check_output("writes_before_abort", wr_log.size(), 456);
        wr_q.delete();
        done_q[0].delete();
        tick(20);
        check_output("idle_after_abort", {busy_v[0], wren_v[0]}, 32'd0);

        // start together with abort in IDLE must not start a run.
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        tick(1);
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        check_output("start_abort_idle", 32'(busy_v[0]), 32'd0);
        tick(3);

        // Fresh run after abort completes from scratch.
        wr_log.delete(); wr_cyc.delete();
        model_run(KEY_A, 3, 1'b1);
        apply_stimulus(0, KEY_A, 1793);
        wait_done(0, 2000);
        check_output("wr_q_drained_restart", wr_q.size(), 0);
        check_ram(0, "ram_restart");

        // Second start mid-run with a different key is ignored.
        $display("[TB] run 3: start while busy, then reset mid-run");
        model_run(KEY_A, 3, 1'b1);
        apply_stimulus(0, KEY_A, 1793);
        while (cyc < t0 + 500) tick(1);
        bus_a.key   = 24'h123456;
        bus_a.start = 1'b1;
        tick(1);
        bus_a.start = 1'b0;
        check_output("busy_after_restart_try", 32'(busy_v[0]), 32'd1);
        wait_done(0, 2000);
        check_output("wr_q_drained_ignored", wr_q.size(), 0);
        check_ram(0, "ram_ignored_start");

        // Reset at cycle 900 of a run forces outputs to zero at once.
        model_run(KEY_A, 3, 1'b1);
        apply_stimulus(0, KEY_A, 1793);
        while (cyc < t0 + 900) tick(1);
        reset = 1'b1;
        #1;
        check_output("reset_midrun_outputs", {busy_v[0], done_v[0], wren_v[0], addr_v[0], wdata_v[0]}, 32'd0);
        tick(2);
        reset = 1'b0;
        wr_q.delete();
        done_q[0].delete();
        tick(5);
        check_output("idle_after_reset", {busy_v[0], done_v[0], wren_v[0]}, 32'd0);

        // 5-byte key on a 3-cycle RAM: 10 cycles per i.
        $display("[TB] run 4: KEY_BYTES=5, MEM_RD_LAT=3");
        model_run(KEY_5, 5, 1'b0);
        apply_stimulus(1, KEY_5, 2817);
        wait_done(1, 3000);
        check_ram(1, "ram_k5_lat3");

        // No fill phase, RAM preloaded with the identity.
        $display("[TB] run 5: INIT_EN=0");
        load_req[2] = 1'b1;
        tick(1);
        load_req[2] = 1'b0;
        model_run(KEY_A, 3, 1'b0);
        apply_stimulus(2, KEY_A, 1537);
        wait_done(2, 1700);
        check_ram(2, "ram_no_init");

        tick(5);
        for (int n = 0; n < 3; n++) begin
            check_output($sformatf("done_q%0d_empty", n), done_q[n].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
